aes_stream_loader: RTL and testbench
====================================

# aes_stream_loader

Word-serial front/back end for the AES encryption core. Collects a 128-bit cipher key and a 128-bit plaintext from a 32-bit valid/ready input stream, presents them to the core with a one-cycle start pulse, and waits for done. It then captures the 128-bit ciphertext and returns it as four 32-bit words on a valid/ready output stream. It sits directly upstream and downstream of the AES top level, with a watchdog against a hung core.

## Interface
- TIMEOUT, 64: maximum cycles in WAIT before the timeout error is raised; must be ≥ 16.
- clk  in  1  single system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  loader accepts a word this cycle.
- in_data  in  32  input word; most-significant word first.
- in_keep_key  in  1  sampled with the first word of a block; 1 = reuse the stored key, so only 4 plaintext words follow.
- aes_start  out  1  one-cycle start pulse to the core.
- aes_cipher_key  out  128  key register, held stable from START until the next block's load.
- aes_plain_text  out  128  plaintext register, same stability rule.
- aes_done  in  1  core completion; may be a pulse or a held level.
- aes_cipher_text  in  128  core result; valid when done rises.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accepts the word.
- out_data  out  32  ciphertext word; most-significant word first.
- out_last  out  1  high with the 4th output word.
- busy  out  1  state ≠ LOAD.
- err_timeout  out  1  one-cycle pulse on watchdog expiry.

## Operation
- States: LOAD, START, WAIT, UNLOAD.
- LOAD
  - in_ready = 1; a word is accepted on in_valid & in_ready.
  - A 3-bit word counter starts at 0.
  - At counter 0, in_keep_key is sampled:
    - If it is 1 and key_valid is set, the key phase is skipped and the counter jumps to 4.
    - If it is 1 and key_valid is clear, it is ignored and the full 8 words are taken.
  - Words 0–3 shift into the key register (word 0 → bits [127:96]). Words 4–7 go into the plaintext register the same way.
  - The accept of word 7 moves the state to START. key_valid is set when word 3 is accepted.
- START
  - aes_start = 1 for exactly one cycle.
  - Watchdog counter cleared.
  - Next state: WAIT.
- WAIT
  - Edge detection: done_q is a register of aes_done. A rising edge is aes_done & ~done_q. A level already high on entry is not a completion.
  - On a rising edge, aes_cipher_text is latched into the output register and the state moves to UNLOAD with out index = 0.
  - The watchdog increments every WAIT cycle. When it reaches TIMEOUT-1 without an edge:
    - err_timeout pulses and the state returns to LOAD.
    - The counter is cleared and key_valid is kept.
    - No output is produced.
  - If the edge and expiry occur in the same cycle, the edge wins.
- UNLOAD
  - out_valid = 1; out_data is word [index] of the latched ciphertext.
  - The index advances on out_valid & out_ready.
  - out_last = (index == 3).
  - The handshake on the last word moves the state to LOAD.
  - out_data and out_last are held stable while out_ready is low.
- Reset
  - State LOAD, counters 0, key_valid 0, done_q 0.
  - Key, plaintext and ciphertext registers are cleared to 0.
  - All outputs low except in_ready (1 in LOAD).
  - Reset mid-operation abandons the block; the next input word is treated as word 0.

## Timing
- Input accept to START: the cycle after word 7 is accepted.
- START to WAIT: 1 cycle.
- done edge to first out_valid: 1 cycle.
- in_ready is 0 in START, WAIT and UNLOAD. There is no input/output overlap.
- Minimum block length, excluding core latency: 8 load + 1 start + 1 edge-capture + 4 unload cycles.
- Watchdog width: clog2(TIMEOUT) bits. No wrap occurs, because expiry forces the state out of WAIT.

## Structure
- Shared package aes_stream_pkg:
  - state enum {LOAD, START, WAIT, UNLOAD};
  - WORD_W = 32, BLK_W = 128, WORDS_PER_BLK = 4.
- Sub-module aes_word_packer (shift-in 4×32 → 128), instantiated twice, for key and plaintext.
- FSM, watchdog and unload mux live in the top of this block.

## Test plan
- Full load, FIPS-197 C.1 vector:
  - stimulus: key 00010203 04050607 08090a0b 0c0d0e0f, then plaintext 00112233 44556677 8899aabb ccddeeff; model core returns done after 12 cycles;
  - required: one aes_start pulse; output words 69c4e0d8 6a7b0430 d8cdb780 70b4c55a in order; out_last on the 4th word.
- Key reuse:
  - stimulus: second block with in_keep_key = 1 and plaintext 00112233 44556677 8899aabb ccddeeff;
  - required: in_ready accepts only 4 words; aes_cipher_key unchanged; same ciphertext produced.
- Backpressure on both sides:
  - stimulus: random in_valid gaps and out_ready low for 5 cycles mid-unload;
  - required: no dropped or duplicated words; out_data is stable while stalled.
- Held-level done:
  - stimulus: aes_done already high entering WAIT, falling 3 cycles later, rising again at cycle 10;
  - required: capture only at the cycle-10 rise.
- Timeout:
  - stimulus: core never raises done, TIMEOUT = 64;
  - required: err_timeout pulses 64 cycles after WAIT entry; state returns to LOAD; out_valid never asserts.
- Reset during WAIT and during UNLOAD:
  - required: all outputs at reset values the next cycle; a subsequent full 8-word block completes correctly.

Source files
------------

// File: rtl/aes_stream_pkg.sv
// Shared types and sizes for the AES word-serial loader.
// Block/word geometry and the loader FSM state encoding.
package aes_stream_pkg;

    localparam int WORD_W        = 32;
    localparam int BLK_W         = 128;
    localparam int WORDS_PER_BLK = 4;

    typedef enum logic [1:0] {
        LOAD,
        START,
        WAIT,
        UNLOAD
    } state_t;

endpackage

// File: rtl/aes_word_packer.sv
// Shift-in packer: four 32-bit words become one 128-bit block,
// first word loaded ends up in the most-significant slot.
module aes_word_packer
    import aes_stream_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [WORD_W-1:0] word,
    output logic [BLK_W-1:0]  blk
);

    logic [WORD_W-1:0] word_reg [WORDS_PER_BLK];

    genvar gi;
    generate
        for (gi = 0; gi < WORDS_PER_BLK; gi++) begin : g_slot
            // New words enter the least-significant slot and move up one slot per load.
            if (gi == WORDS_PER_BLK - 1) begin : g_tail
                always_ff @(posedge clk) begin
                    if (rst) begin
                        word_reg[gi] <= '0;
                    end else if (load) begin
                        word_reg[gi] <= word;
                    end
                end
            end else begin : g_body
                always_ff @(posedge clk) begin
                    if (rst) begin
                        word_reg[gi] <= '0;
                    end else if (load) begin
                        word_reg[gi] <= word_reg[gi+1];
                    end
                end
            end
            assign blk[BLK_W-1-gi*WORD_W -: WORD_W] = word_reg[gi];
        end
    endgenerate

endmodule

// File: rtl/aes_stream_loader.sv
// Word-serial front/back end for the AES core: loads key/plaintext, starts
// the core, waits for a done edge (with watchdog) and streams out the result.
module aes_stream_loader
    import aes_stream_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_keep_key,
    output logic              aes_start,
    output logic [BLK_W-1:0]  aes_cipher_key,
    output logic [BLK_W-1:0]  aes_plain_text,
    input  logic              aes_done,
    input  logic [BLK_W-1:0]  aes_cipher_text,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              err_timeout
);

    localparam int WD_W = $clog2(TIMEOUT);

    state_t            state_reg, state_next;
    logic [2:0]        cnt_reg, cnt_next;
    logic [WD_W-1:0]   wdog_reg, wdog_next;
    logic [1:0]        idx_reg, idx_next;
    logic              key_valid_reg, key_valid_next;
    logic              done_q_reg;
    logic [BLK_W-1:0]  ct_reg, ct_next;
    logic              err_reg, err_next;

    logic              accept;
    logic              done_rise;
    logic              key_load;
    logic              pt_load;
    logic [2:0]        eff_idx;
    logic [WORD_W-1:0] ct_words [WORDS_PER_BLK];

    assign accept    = in_valid & (state_reg == LOAD);
    assign done_rise = aes_done & ~done_q_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= LOAD;
            cnt_reg       <= '0;
            wdog_reg      <= '0;
            idx_reg       <= '0;
            key_valid_reg <= 1'b0;
            done_q_reg    <= 1'b0;
            ct_reg        <= '0;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            wdog_reg      <= wdog_next;
            idx_reg       <= idx_next;
            key_valid_reg <= key_valid_next;
            done_q_reg    <= aes_done;
            ct_reg        <= ct_next;
            err_reg       <= err_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        wdog_next      = wdog_reg;
        idx_next       = idx_reg;
        key_valid_next = key_valid_reg;
        ct_next        = ct_reg;
        err_next       = 1'b0;
        key_load       = 1'b0;
        pt_load        = 1'b0;
        // A key-reuse request on the first word makes that word plaintext word 0.
        eff_idx        = (cnt_reg == 3'd0 && in_keep_key && key_valid_reg) ? 3'd4 : cnt_reg;

        case (state_reg)
            LOAD: begin
                if (accept) begin
                    key_load = ~eff_idx[2];
                    pt_load  = eff_idx[2];
                    if (eff_idx == 3'd3) begin
                        key_valid_next = 1'b1;
                    end
                    if (eff_idx == 3'd7) begin
                        cnt_next   = 3'd0;
                        state_next = START;
                    end else begin
                        cnt_next = eff_idx + 3'd1;
                    end
                end
            end
            START: begin
                wdog_next  = '0;
                state_next = WAIT;
            end
            WAIT: begin
                // The done edge takes priority over a simultaneous watchdog expiry.
                if (done_rise) begin
                    ct_next    = aes_cipher_text;
                    idx_next   = 2'd0;
                    state_next = UNLOAD;
                end else if (wdog_reg == WD_W'(TIMEOUT - 1)) begin
                    err_next   = 1'b1;
                    wdog_next  = '0;
                    cnt_next   = 3'd0;
                    state_next = LOAD;
                end else begin
                    wdog_next = wdog_reg + 1'b1;
                end
            end
            UNLOAD: begin
                if (out_ready) begin
                    if (idx_reg == 2'd3) begin
                        idx_next   = 2'd0;
                        state_next = LOAD;
                    end else begin
                        idx_next = idx_reg + 2'd1;
                    end
                end
            end
            default: begin
                state_next = LOAD;
            end
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < WORDS_PER_BLK; gi++) begin : g_ct_word
            assign ct_words[gi] = ct_reg[BLK_W-1-gi*WORD_W -: WORD_W];
        end
    endgenerate

    aes_word_packer u_key_packer (
        .clk  (clk),
        .rst  (rst),
        .load (key_load),
        .word (in_data),
        .blk  (aes_cipher_key)
    );

    aes_word_packer u_pt_packer (
        .clk  (clk),
        .rst  (rst),
        .load (pt_load),
        .word (in_data),
        .blk  (aes_plain_text)
    );

    assign in_ready    = (state_reg == LOAD);
    assign busy        = (state_reg != LOAD);
    assign aes_start   = (state_reg == START);
    assign out_valid   = (state_reg == UNLOAD);
    assign out_last    = (state_reg == UNLOAD) && (idx_reg == 2'd3);
    assign out_data    = (state_reg == UNLOAD) ? ct_words[idx_reg] : '0;
    assign err_timeout = err_reg;

endmodule

// File: tb/tb_aes_stream_loader.sv
// Directed bench for aes_stream_loader: drives both streams and plays the
// role of the AES core; inputs change and outputs are sampled on negedge.
module tb_aes_stream_loader;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic         in_keep_key;
    logic         aes_start;
    logic [127:0] aes_cipher_key;
    logic [127:0] aes_plain_text;
    logic         aes_done;
    logic [127:0] aes_cipher_text;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_data;
    logic         out_last;
    logic         busy;
    logic         err_timeout;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] KEY      = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT       = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT       = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KEY2     = 128'hdeadbeefcafef00d1357924680aceace;
    localparam logic [127:0] PT2      = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    localparam logic [127:0] CT2      = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] CT3      = 128'ha5a5a5a55a5a5a5a3c3c3c3cc3c3c3c3;
    localparam logic [127:0] CT_EARLY = 128'hbadbadbadbadbadbadbadbadbadbad00;

    logic [127:0] exp_blk;
    logic [31:0]  exp_w;
    logic [31:0]  hold_w;
    int           bad;

    always #5 clk = ~clk;

    aes_stream_loader #(.TIMEOUT(64)) dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_data         (in_data),
        .in_keep_key     (in_keep_key),
        .aes_start       (aes_start),
        .aes_cipher_key  (aes_cipher_key),
        .aes_plain_text  (aes_plain_text),
        .aes_done        (aes_done),
        .aes_cipher_text (aes_cipher_text),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_data        (out_data),
        .out_last        (out_last),
        .busy            (busy),
        .err_timeout     (err_timeout)
    );

    // Stimulus only: four words of blk, MS word first, optional idle gaps.
    task automatic put_block(input logic [127:0] blk, input logic keep_first, input int max_gap);
        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(0, max_gap)) @(negedge clk);
            in_valid    = 1'b1;
            in_data     = blk[127-32*i -: 32];
            in_keep_key = (i == 0) ? keep_first : 1'b0;
            @(negedge clk);
            in_valid    = 1'b0;
            in_keep_key = 1'b0;
            $display("in word %0d = %h", i, blk[127-32*i -: 32]);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({in_ready, busy, aes_start, out_valid, out_last, err_timeout} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 100000",
                     {in_ready, busy, aes_start, out_valid, out_last, err_timeout});
        end
        checks++;
        if (aes_cipher_key !== '0 || aes_plain_text !== '0 || out_data !== '0) begin
            errors++;
            $display("FAIL reset_data: got key=%h pt=%h out=%h expected all zero",
                     aes_cipher_key, aes_plain_text, out_data);
        end
        rst = 1'b0;
    endtask

    task automatic test_full_load;
        put_block(KEY, 1'b0, 0);
        put_block(PT, 1'b0, 0);
        checks++;
        if (aes_start !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL c1_start: got start=%b in_ready=%b expected start=1 in_ready=0", aes_start, in_ready);
        end
        checks++;
        if (aes_cipher_key !== KEY || aes_plain_text !== PT) begin
            errors++;
            $display("FAIL c1_regs: got key=%h pt=%h expected key=%h pt=%h", aes_cipher_key, aes_plain_text, KEY, PT);
        end
        bad = 0;
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            if (aes_start !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL c1_wait: got %0d bad wait cycles expected 0", bad);
        end
        aes_cipher_text = CT;
        aes_done = 1'b1;
        @(negedge clk);
        aes_done = 1'b0;
        exp_blk = CT;
        for (int i = 0; i < 4; i++) begin
            exp_w = exp_blk[127-32*i -: 32];
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_w || out_last !== (i == 3)) begin
                errors++;
                $display("FAIL c1_word%0d: got v=%b d=%h l=%b expected v=1 d=%h l=%b",
                         i, out_valid, out_data, out_last, exp_w, (i == 3));
            end
            $display("c1 out word %0d = %h", i, out_data);
            @(negedge clk);
        end
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL c1_end: got v=%b busy=%b rdy=%b expected 0 0 1", out_valid, busy, in_ready);
        end
    endtask

    task automatic test_key_reuse;
        put_block(PT, 1'b1, 0);
        checks++;
        if (aes_start !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reuse_start_after4: got start=%b in_ready=%b expected 1 0", aes_start, in_ready);
        end
        checks++;
        if (aes_cipher_key !== KEY || aes_plain_text !== PT) begin
            errors++;
            $display("FAIL reuse_regs: got key=%h pt=%h expected key=%h pt=%h", aes_cipher_key, aes_plain_text, KEY, PT);
        end
        repeat (3) @(negedge clk);
        aes_cipher_text = CT;
        aes_done = 1'b1;
        @(negedge clk);
        aes_done = 1'b0;
        exp_blk = CT;
        for (int i = 0; i < 4; i++) begin
            exp_w = exp_blk[127-32*i -: 32];
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_w || out_last !== (i == 3)) begin
                errors++;
                $display("FAIL reuse_word%0d: got v=%b d=%h l=%b expected v=1 d=%h l=%b",
                         i, out_valid, out_data, out_last, exp_w, (i == 3));
            end
            $display("reuse out word %0d = %h", i, out_data);
            @(negedge clk);
        end
        checks++;
        if (aes_cipher_key !== KEY || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reuse_end: got key=%h v=%b expected key=%h v=0", aes_cipher_key, out_valid, KEY);
        end
    endtask

    task automatic test_backpressure;
        put_block(KEY2, 1'b0, 3);
        put_block(PT2, 1'b0, 3);
        checks++;
        if (aes_start !== 1'b1 || aes_cipher_key !== KEY2 || aes_plain_text !== PT2) begin
            errors++;
            $display("FAIL bp_regs: got start=%b key=%h pt=%h expected 1 %h %h",
                     aes_start, aes_cipher_key, aes_plain_text, KEY2, PT2);
        end
        repeat (2) @(negedge clk);
        aes_cipher_text = CT2;
        aes_done = 1'b1;
        @(negedge clk);
        aes_done = 1'b0;
        exp_blk = CT2;
        for (int i = 0; i < 4; i++) begin
            exp_w = exp_blk[127-32*i -: 32];
            if (i == 2) begin
                out_ready = 1'b0;
                bad = 0;
                hold_w = out_data;
                repeat (5) begin
                    if (out_valid !== 1'b1 || out_data !== hold_w || out_data !== exp_w || out_last !== 1'b0) bad++;
                    @(negedge clk);
                end
                checks++;
                if (bad != 0) begin
                    errors++;
                    $display("FAIL bp_stall: got %0d unstable stall cycles expected 0", bad);
                end
                out_ready = 1'b1;
            end
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_w || out_last !== (i == 3)) begin
                errors++;
                $display("FAIL bp_word%0d: got v=%b d=%h l=%b expected v=1 d=%h l=%b",
                         i, out_valid, out_data, out_last, exp_w, (i == 3));
            end
            $display("bp out word %0d = %h", i, out_data);
            @(negedge clk);
        end
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_no_extra: got v=%b rdy=%b expected 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_held_done;
        aes_done = 1'b1;
        aes_cipher_text = CT_EARLY;
        put_block(PT, 1'b1, 0);
        checks++;
        if (aes_start !== 1'b1) begin
            errors++;
            $display("FAIL held_start: got %b expected 1", aes_start);
        end
        bad = 0;
        for (int c = 0; c <= 10; c++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) bad++;
            aes_done = (c < 3) || (c >= 10);
            aes_cipher_text = (c >= 10) ? CT3 : CT_EARLY;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL held_early_capture: got %0d early out_valid cycles expected 0", bad);
        end
        @(negedge clk);
        aes_cipher_text = CT_EARLY;
        exp_blk = CT3;
        for (int i = 0; i < 4; i++) begin
            exp_w = exp_blk[127-32*i -: 32];
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_w || out_last !== (i == 3)) begin
                errors++;
                $display("FAIL held_word%0d: got v=%b d=%h l=%b expected v=1 d=%h l=%b",
                         i, out_valid, out_data, out_last, exp_w, (i == 3));
            end
            $display("held out word %0d = %h", i, out_data);
            @(negedge clk);
        end
        aes_done = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_timeout;
        put_block(PT, 1'b1, 0);
        checks++;
        if (aes_start !== 1'b1) begin
            errors++;
            $display("FAIL to_start: got %b expected 1", aes_start);
        end
        bad = 0;
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk);
            if (err_timeout !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL to_early: got %0d bad cycles before expiry expected 0", bad);
        end
        @(negedge clk);
        checks++;
        if (err_timeout !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL to_pulse: got err=%b busy=%b rdy=%b v=%b expected 1 0 1 0",
                     err_timeout, busy, in_ready, out_valid);
        end
        @(negedge clk);
        checks++;
        if (err_timeout !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL to_one_cycle: got err=%b v=%b expected 0 0", err_timeout, out_valid);
        end
    endtask

    task automatic test_reset_wait;
        // Key must still be valid after the timeout: only 4 words needed.
        put_block(PT, 1'b1, 0);
        checks++;
        if (aes_start !== 1'b1) begin
            errors++;
            $display("FAIL rw_keep_after_timeout: got start=%b expected 1", aes_start);
        end
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({in_ready, busy, aes_start, out_valid, out_last, err_timeout} !== 6'b100000 ||
            aes_cipher_key !== '0 || aes_plain_text !== '0) begin
            errors++;
            $display("FAIL rw_reset: got flags=%b key=%h pt=%h expected 100000 and zeros",
                     {in_ready, busy, aes_start, out_valid, out_last, err_timeout}, aes_cipher_key, aes_plain_text);
        end
        rst = 1'b0;
        put_block(KEY, 1'b0, 1);
        put_block(PT, 1'b0, 1);
        checks++;
        if (aes_start !== 1'b1 || aes_cipher_key !== KEY || aes_plain_text !== PT) begin
            errors++;
            $display("FAIL rw_reload: got start=%b key=%h pt=%h", aes_start, aes_cipher_key, aes_plain_text);
        end
        @(negedge clk);
        aes_cipher_text = CT;
        aes_done = 1'b1;
        @(negedge clk);
        aes_done = 1'b0;
        exp_blk = CT;
        for (int i = 0; i < 4; i++) begin
            exp_w = exp_blk[127-32*i -: 32];
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_w || out_last !== (i == 3)) begin
                errors++;
                $display("FAIL rw_word%0d: got v=%b d=%h l=%b expected v=1 d=%h l=%b",
                         i, out_valid, out_data, out_last, exp_w, (i == 3));
            end
            $display("rw out word %0d = %h", i, out_data);
            @(negedge clk);
        end
    endtask

    task automatic test_reset_unload;
        put_block(KEY2, 1'b0, 0);
        put_block(PT2, 1'b0, 0);
        @(negedge clk);
        aes_cipher_text = CT2;
        aes_done = 1'b1;
        @(negedge clk);
        aes_done = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({in_ready, busy, aes_start, out_valid, out_last, err_timeout} !== 6'b100000 || out_data !== '0) begin
            errors++;
            $display("FAIL ru_reset: got flags=%b out=%h expected 100000 and zero",
                     {in_ready, busy, aes_start, out_valid, out_last, err_timeout}, out_data);
        end
        rst = 1'b0;
        // key_valid was cleared, so keep_key must be ignored and all 8 words taken.
        put_block(KEY, 1'b1, 0);
        checks++;
        if (aes_start !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ru_keep_ignored: got start=%b rdy=%b expected 0 1", aes_start, in_ready);
        end
        put_block(PT, 1'b0, 0);
        checks++;
        if (aes_start !== 1'b1 || aes_cipher_key !== KEY || aes_plain_text !== PT) begin
            errors++;
            $display("FAIL ru_reload: got start=%b key=%h pt=%h", aes_start, aes_cipher_key, aes_plain_text);
        end
        @(negedge clk);
        aes_cipher_text = CT;
        aes_done = 1'b1;
        @(negedge clk);
        aes_done = 1'b0;
        exp_blk = CT;
        for (int i = 0; i < 4; i++) begin
            exp_w = exp_blk[127-32*i -: 32];
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_w || out_last !== (i == 3)) begin
                errors++;
                $display("FAIL ru_word%0d: got v=%b d=%h l=%b expected v=1 d=%h l=%b",
                         i, out_valid, out_data, out_last, exp_w, (i == 3));
            end
            $display("ru out word %0d = %h", i, out_data);
            @(negedge clk);
        end
    endtask

    initial begin
        rst             = 1'b1;
        in_valid        = 1'b0;
        in_data         = '0;
        in_keep_key     = 1'b0;
        aes_done        = 1'b0;
        aes_cipher_text = '0;
        out_ready       = 1'b1;
        test_reset();
        test_full_load();
        test_key_reuse();
        test_backpressure();
        test_held_done();
        test_timeout();
        test_reset_wait();
        test_reset_unload();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_time_limit: simulation did not finish within 200000 time units");
        $fatal(1);
    end

endmodule
